// File: rtl/jtag_arbiter.sv
// Two-requester round-robin arbiter in front of a JTAG engine: it loads the engine's
// instruction/data FIFOs for one command, starts the engine, and reports done/err.
module jtag_arbiter #(
    parameter int unsigned DATA_INSTRUCTION = 6,
    parameter int unsigned DATA_FIFO        = 8,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned TIMEOUT          = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      req,
    input  logic [2*DATA_INSTRUCTION-1:0]   req_instr,
    input  logic [15:0]                     req_len,
    input  logic [2*DATA_FIFO-1:0]          req_data,
    input  logic [1:0]                      req_data_valid,
    output logic [1:0]                      req_data_ready,
    output logic [1:0]                      grant,
    output logic [1:0]                      done,
    output logic                            err,
    output logic [DATA_INSTRUCTION-1:0]     wdata_instruction,
    output logic                            wr_instruction,
    input  logic                            full_instruction,
    output logic [DATA_FIFO-1:0]            wdata_data,
    output logic                            wr_data,
    input  logic                            full_data,
    output logic                            op,
    output logic [7:0]                      len,
    input  logic                            busy,
    input  logic                            end_op,
    output logic                            conf_op
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_I = 3'd1;
    localparam logic [2:0] LOAD_D = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;
    localparam logic [2:0] ACK    = 3'd5;

    localparam int WD_W = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);

    logic [2:0]                  state;
    logic [1:0]                  grant_q;
    logic                        ptr;
    logic [DATA_INSTRUCTION-1:0] instr_q;
    logic [7:0]                  len_q;
    logic [7:0]                  cnt;
    logic [WD_W-1:0]             wd;
    logic                        err_q;

    logic                        g;
    logic                        cand;
    logic [DATA_INSTRUCTION-1:0] cand_instr;
    logic [7:0]                  cand_len;
    logic                        g_valid;
    logic [DATA_FIFO-1:0]        g_data;

    // Pointer names the favoured requester; fall back to the other one if it is idle.
    assign cand       = req[ptr] ? ptr : ~ptr;
    assign cand_instr = cand ? req_instr[2*DATA_INSTRUCTION-1:DATA_INSTRUCTION]
                             : req_instr[DATA_INSTRUCTION-1:0];
    assign cand_len   = cand ? req_len[15:8] : req_len[7:0];

    assign g       = grant_q[1];
    assign g_valid = g ? req_data_valid[1] : req_data_valid[0];
    assign g_data  = g ? req_data[2*DATA_FIFO-1:DATA_FIFO] : req_data[DATA_FIFO-1:0];
    assign grant   = grant_q;

    always_comb begin
        req_data_ready    = '0;
        wdata_instruction = '0;
        wr_instruction    = 1'b0;
        wdata_data        = '0;
        wr_data           = 1'b0;
        op                = 1'b0;
        len               = '0;
        conf_op           = 1'b0;
        done              = '0;
        err               = 1'b0;
        case (state)
            LOAD_I: begin
                wdata_instruction = instr_q;
                wr_instruction    = !full_instruction;
            end
            LOAD_D: begin
                wdata_data        = g_data;
                req_data_ready[g] = !full_data;
                wr_data           = g_valid && !full_data;
            end
            START: begin
                op  = 1'b1;
                len = len_q;
            end
            WAIT: len = len_q;
            ACK: begin
                done    = grant_q;
                err     = err_q;
                conf_op = !err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr     <= 1'b0;
            instr_q <= '0;
            len_q   <= '0;
            cnt     <= '0;
            wd      <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00 && !busy) begin
                        grant_q <= cand ? 2'b10 : 2'b01;
                        instr_q <= cand_instr;
                        len_q   <= cand_len;
                        cnt     <= '0;
                        if (32'(cand_len) > FIFO_DEPTH) begin
                            err_q <= 1'b1;
                            state <= ACK;
                        end else begin
                            err_q <= 1'b0;
                            state <= LOAD_I;
                        end
                    end
                end
                LOAD_I: begin
                    if (!full_instruction)
                        state <= (len_q != 8'd0) ? LOAD_D : START;
                end
                LOAD_D: begin
                    if (wr_data) begin
                        cnt <= cnt + 8'd1;
                        if (cnt == len_q - 8'd1)
                            state <= START;
                    end
                end
                START: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // end_op is tested first so it wins over a coincident timeout.
                    if (end_op) begin
                        err_q <= 1'b0;
                        state <= ACK;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= ACK;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                ACK: begin
                    ptr     <= ~g;
                    grant_q <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_arbiter.sv
// Directed bench for jtag_arbiter: a cycle table for the basic transfer plus
// hand-written sequences for stalls, rejection, timeout, reset and alternation.
module tb_jtag_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [11:0] req_instr;
    logic [15:0] req_len;
    logic [15:0] req_data;
    logic [1:0]  req_data_valid;
    logic [1:0]  req_data_ready;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic        err;
    logic [5:0]  wdata_instruction;
    logic        wr_instruction;
    logic        full_instruction;
    logic [7:0]  wdata_data;
    logic        wr_data;
    logic        full_data;
    logic        op;
    logic [7:0]  len;
    logic        busy;
    logic        end_op;
    logic        conf_op;

    always #5 clk = ~clk;

    jtag_arbiter #(
        .DATA_INSTRUCTION(6),
        .DATA_FIFO(8),
        .FIFO_DEPTH(16),
        .TIMEOUT(20)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_instr(req_instr), .req_len(req_len),
        .req_data(req_data), .req_data_valid(req_data_valid), .req_data_ready(req_data_ready),
        .grant(grant), .done(done), .err(err),
        .wdata_instruction(wdata_instruction), .wr_instruction(wr_instruction),
        .full_instruction(full_instruction),
        .wdata_data(wdata_data), .wr_data(wr_data), .full_data(full_data),
        .op(op), .len(len), .busy(busy), .end_op(end_op), .conf_op(conf_op)
    );

    int checks = 0;
    int errors = 0;

    int n_wri = 0, n_wrd = 0, n_op = 0, n_conf = 0, n_done = 0, n_viol = 0;
    logic [5:0] wri_log [256];
    logic [7:0] wrd_log [256];

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_instruction) begin
                if (n_wri < 256) wri_log[n_wri] <= wdata_instruction;
                n_wri <= n_wri + 1;
            end
            if (wr_data) begin
                if (n_wrd < 256) wrd_log[n_wrd] <= wdata_data;
                n_wrd <= n_wrd + 1;
            end
            if ((wr_instruction && full_instruction) || (wr_data && full_data))
                n_viol <= n_viol + 1;
            if (op)      n_op   <= n_op + 1;
            if (conf_op) n_conf <= n_conf + 1;
            if (|done)   n_done <= n_done + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] outs();
        return {grant, wr_instruction, wdata_instruction, wr_data, wdata_data,
                req_data_ready, op, len, conf_op, done, err};
    endfunction

    task automatic wait_op(input int budget, output logic found);
        int cyc = 0;
        found = 1'b0;
        while (!found && cyc < budget) begin
            @(negedge clk);
            if (op) found = 1'b1;
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int budget, output logic [1:0] d, output logic e,
                             output logic c, output int cycles);
        logic found = 1'b0;
        d = 2'b00; e = 1'b0; c = 1'b0; cycles = 0;
        while (!found && cycles < budget) begin
            @(negedge clk);
            if (|done) begin
                found = 1'b1; d = done; e = err; c = conf_op;
            end else begin
                cycles++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_idle();
        req = 2'b00; req_instr = '0; req_len = '0; req_data = '0; req_data_valid = 2'b00;
        full_instruction = 1'b0; full_data = 1'b0; busy = 1'b0; end_op = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] req;   logic busy; logic [1:0] valid; logic [7:0] d0;
        logic fi;          logic fd;   logic eo;
        logic [1:0] x_grant; logic x_wri; logic [5:0] x_wdi; logic x_wrd; logic [7:0] x_wdd;
        logic [1:0] x_rdy;   logic x_op;  logic [7:0] x_len; logic x_conf; logic [1:0] x_done;
        logic x_err;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [1:0] d;
        logic       e, c, found, acc, saw_op;
        int         cy, base_wri, base_wrd, base_op, base_conf, base_done, idx, stalled, stall_bad;
        logic [7:0] words [3];

        // Table columns: req busy valid d0 full_i full_d end_op | grant wr_i wdata_i wr_d wdata_d ready op len conf done err
        vecs[0]  = '{2'b01,1'b1,2'b00,8'h00,1'b0,1'b0,1'b0, 2'b00,1'b0,6'h00,1'b0,8'h00,2'b00,1'b0,8'd0,1'b0,2'b00,1'b0};
        vecs[1]  = '{2'b01,1'b0,2'b00,8'h00,1'b0,1'b0,1'b0, 2'b00,1'b0,6'h00,1'b0,8'h00,2'b00,1'b0,8'd0,1'b0,2'b00,1'b0};
        vecs[2]  = '{2'b01,1'b0,2'b00,8'h00,1'b1,1'b0,1'b0, 2'b01,1'b0,6'h0A,1'b0,8'h00,2'b00,1'b0,8'd0,1'b0,2'b00,1'b0};
        vecs[3]  = '{2'b01,1'b0,2'b00,8'h00,1'b0,1'b0,1'b0, 2'b01,1'b1,6'h0A,1'b0,8'h00,2'b00,1'b0,8'd0,1'b0,2'b00,1'b0};
        vecs[4]  = '{2'b01,1'b0,2'b01,8'hA1,1'b0,1'b0,1'b0, 2'b01,1'b0,6'h00,1'b1,8'hA1,2'b01,1'b0,8'd0,1'b0,2'b00,1'b0};
        vecs[5]  = '{2'b01,1'b0,2'b01,8'hA2,1'b0,1'b0,1'b0, 2'b01,1'b0,6'h00,1'b1,8'hA2,2'b01,1'b0,8'd0,1'b0,2'b00,1'b0};
        vecs[6]  = '{2'b01,1'b0,2'b01,8'hA3,1'b0,1'b0,1'b0, 2'b01,1'b0,6'h00,1'b1,8'hA3,2'b01,1'b0,8'd0,1'b0,2'b00,1'b0};
        vecs[7]  = '{2'b01,1'b0,2'b00,8'h00,1'b0,1'b0,1'b0, 2'b01,1'b0,6'h00,1'b0,8'h00,2'b00,1'b1,8'd3,1'b0,2'b00,1'b0};
        for (int i = 8; i < 12; i++)
            vecs[i] = '{2'b01,1'b0,2'b00,8'h00,1'b0,1'b0,1'b0, 2'b01,1'b0,6'h00,1'b0,8'h00,2'b00,1'b0,8'd3,1'b0,2'b00,1'b0};
        vecs[12] = '{2'b01,1'b0,2'b00,8'h00,1'b0,1'b0,1'b1, 2'b01,1'b0,6'h00,1'b0,8'h00,2'b00,1'b0,8'd3,1'b0,2'b00,1'b0};
        vecs[13] = '{2'b01,1'b0,2'b00,8'h00,1'b0,1'b0,1'b0, 2'b01,1'b0,6'h00,1'b0,8'h00,2'b00,1'b0,8'd0,1'b1,2'b01,1'b0};
        vecs[14] = '{2'b00,1'b0,2'b00,8'h00,1'b0,1'b0,1'b0, 2'b00,1'b0,6'h00,1'b0,8'h00,2'b00,1'b0,8'd0,1'b0,2'b00,1'b0};

        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        check("reset_outputs", outs(), 33'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic transfer, cycle by cycle: instr 0A, len 3, words A1..A3, end_op 5 cycles after op.
        req_instr = {6'h33, 6'h0A};
        req_len   = {8'd9, 8'd3};
        for (int i = 0; i < 15; i++) begin
            req = vecs[i].req; busy = vecs[i].busy; req_data_valid = vecs[i].valid;
            req_data = {8'h5B, vecs[i].d0};
            full_instruction = vecs[i].fi; full_data = vecs[i].fd; end_op = vecs[i].eo;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].x_grant, vecs[i].x_wri, vecs[i].x_wdi, vecs[i].x_wrd, vecs[i].x_wdd,
                   vecs[i].x_rdy, vecs[i].x_op, vecs[i].x_len, vecs[i].x_conf, vecs[i].x_done,
                   vecs[i].x_err});
            @(posedge clk); #1;
        end
        drive_idle();

        // full_data back-pressure for 4 cycles after the first word.
        words[0] = 8'hB1; words[1] = 8'hB2; words[2] = 8'hB3;
        base_wrd = n_wrd;
        req = 2'b01; req_instr = {6'h00, 6'h15}; req_len = {8'd0, 8'd3};
        idx = 0; stalled = 0; stall_bad = 0; saw_op = 1'b0;
        for (int cyc = 0; cyc < 40 && !saw_op; cyc++) begin
            full_data = (idx == 1 && stalled < 4);
            req_data_valid = (idx < 3) ? 2'b01 : 2'b00;
            req_data = {8'h5B, (idx < 3) ? words[idx] : 8'h00};
            @(negedge clk);
            if (full_data) begin
                stalled++;
                if (req_data_ready != 2'b00 || wr_data) stall_bad++;
            end
            acc = req_data_ready[0] & req_data_valid[0];
            saw_op = op;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        full_data = 1'b0; req_data_valid = 2'b00;
        check("stall_no_ready_no_write", stall_bad, 0);
        check("stall_op_seen", saw_op, 1);
        check("stall_word_count", n_wrd - base_wrd, 3);
        for (int k = 0; k < 3; k++)
            check($sformatf("stall_word%0d", k), wrd_log[base_wrd + k], words[k]);
        end_op = 1'b1;
        wait_done(10, d, e, c, cy);
        end_op = 1'b0; req = 2'b00;
        check("stall_done", {d, e, c}, {2'b01, 1'b0, 1'b1});

        // Oversized command from requester 1 is rejected without touching the FIFOs.
        base_wri = n_wri; base_wrd = n_wrd; base_op = n_op; base_conf = n_conf;
        req = 2'b10; req_len = {8'd17, 8'd0}; req_instr = {6'h3F, 6'h00};
        wait_done(6, d, e, c, cy);
        req = 2'b00;
        check("reject_done_err", {d, e, c}, {2'b10, 1'b1, 1'b0});
        check("reject_latency_le2", cy <= 2, 1);
        check("reject_no_writes", {n_wri - base_wri, n_wrd - base_wrd}, 0);
        check("reject_no_op_conf", {n_op - base_op, n_conf - base_conf}, 0);

        // Watchdog: no end_op -> err exactly 20 cycles after WAIT entry.
        req = 2'b01; req_len = {8'd0, 8'd0}; req_instr = {6'h00, 6'h2C};
        wait_op(10, found);
        check("timeout_op_seen", found, 1);
        wait_done(40, d, e, c, cy);
        req = 2'b00;
        check("timeout_done_err", {d, e, c}, {2'b01, 1'b1, 1'b0});
        check("timeout_cycles", cy, 20);

        // end_op in the final watchdog cycle wins over the timeout.
        req = 2'b01;
        wait_op(10, found);
        check("limit_op_seen", found, 1);
        repeat (19) begin @(posedge clk); #1; end
        end_op = 1'b1;
        wait_done(10, d, e, c, cy);
        end_op = 1'b0; req = 2'b00;
        check("limit_done_ok", {d, e, c}, {2'b01, 1'b0, 1'b1});
        check("limit_latency", 19 + cy, 20);

        // Reset during LOAD_D after one of three words.
        base_done = n_done; base_conf = n_conf;
        req = 2'b01; req_len = {8'd0, 8'd3}; req_data_valid = 2'b01; req_data = {8'h5B, 8'hC1};
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            if (wr_data) found = 1'b1;
            @(posedge clk); #1;
        end
        check("rst_first_word_seen", found, 1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", outs(), 33'd0);
        req_data_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_idle_grant", grant, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_regrant", grant, 2'b01);
        check("rst_no_done_conf", {n_done - base_done, n_conf - base_conf}, 0);
        @(posedge clk); #1;

        // Both requesting, len 0: strict alternation starting at requester 0.
        do_reset();
        base_wri = n_wri; base_wrd = n_wrd;
        req = 2'b11; req_len = 16'd0; req_instr = {6'h22, 6'h11};
        for (int k = 0; k < 4; k++) begin
            wait_op(10, found);
            check($sformatf("alt_op%0d", k), found, 1);
            end_op = 1'b1;
            wait_done(10, d, e, c, cy);
            end_op = 1'b0;
            check($sformatf("alt_done%0d", k), {d, e}, {(k % 2 == 0) ? 2'b01 : 2'b10, 1'b0});
        end
        req = 2'b00;
        check("alt_instr_count", n_wri - base_wri, 4);
        check("alt_no_data", n_wrd - base_wrd, 0);
        for (int k = 0; k < 4; k++)
            check($sformatf("alt_instr%0d", k), wri_log[base_wri + k], (k % 2 == 0) ? 6'h11 : 6'h22);

        check("write_while_full", n_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
